// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer: central stall/flush sequencer and halt-drain FSM.
// Ports: CLK, nRST (async active-low); ihit, dhit, dmemREN_mem, dmemWEN_mem,
//   loaduse, jump_dc, mispredict_mem, halt_mem in; freeze[3:0], flush[3:0],
//   pc_en, halted out (latch bits: 0 IF/ID, 1 ID/EX, 2 EX/MEM, 3 MEM/WB).
//   Optional PIPELINE_SEQ_PERF_CNT_EN adds stall_cycles/flush_events [31:0].
module pipeline_sequencer (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       ihit,
    input  logic       dhit,
    input  logic       dmemREN_mem,
    input  logic       dmemWEN_mem,
    input  logic       loaduse,
    input  logic       jump_dc,
    input  logic       mispredict_mem,
    input  logic       halt_mem,
    output logic [3:0] freeze,
    output logic [3:0] flush,
    output logic       pc_en,
    output logic       halted
`ifdef PIPELINE_SEQ_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
`endif
);

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } state_t;

    state_t state, next_state;
    logic   dstall;

    assign dstall = (dmemREN_mem | dmemWEN_mem) & ~dhit;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= RUN;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        freeze     = 4'b0000;
        flush      = 4'b0000;
        pc_en      = 1'b0;
        halted     = 1'b0;
        unique case (state)
            RUN: begin
                if (dstall) begin
                    // MEM/WB is bubbled so the stalled access is not retired twice
                    freeze = 4'b0111;
                    flush  = 4'b1000;
                end else if (halt_mem) begin
                    flush      = 4'b0111;
                    next_state = DRAIN;
                end else if (mispredict_mem) begin
                    flush = 4'b0111;
                    pc_en = 1'b1;
                end else if (loaduse) begin
                    freeze = 4'b0001;
                    flush  = 4'b0010;
                end else if (jump_dc) begin
                    flush = 4'b0001;
                    pc_en = ihit;
                end else if (!ihit) begin
                    flush = 4'b0001;
                end else begin
                    pc_en = 1'b1;
                end
            end
            DRAIN: begin
                // MEM/WB is left alone so the last instruction writes back
                flush      = 4'b0111;
                next_state = HALTED;
            end
            HALTED: begin
                freeze = 4'b1111;
                halted = 1'b1;
            end
            default: next_state = RUN;
        endcase
        // reset overrides outputs combinationally, released as soon as nRST rises
        if (!nRST) begin
            next_state = RUN;
            freeze     = 4'b0000;
            flush      = 4'b1111;
            pc_en      = 1'b0;
            halted     = 1'b0;
        end
    end

`ifdef PIPELINE_SEQ_PERF_CNT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else if (state == RUN) begin
            if (!pc_en && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if ((|flush) && flush_events != 32'hFFFF_FFFF)
                flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer: directed self-checking bench for pipeline_sequencer.
// Expected values are hand-computed from the priority table.
module tb_pipeline_sequencer;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       ihit, dhit, dmemREN_mem, dmemWEN_mem;
    logic       loaduse, jump_dc, mispredict_mem, halt_mem;
    logic [3:0] freeze, flush;
    logic       pc_en, halted;
`ifdef PIPELINE_SEQ_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    pipeline_sequencer dut (
        .CLK(CLK),
        .nRST(nRST),
        .ihit(ihit),
        .dhit(dhit),
        .dmemREN_mem(dmemREN_mem),
        .dmemWEN_mem(dmemWEN_mem),
        .loaduse(loaduse),
        .jump_dc(jump_dc),
        .mispredict_mem(mispredict_mem),
        .halt_mem(halt_mem),
        .freeze(freeze),
        .flush(flush),
        .pc_en(pc_en),
        .halted(halted)
`ifdef PIPELINE_SEQ_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
`endif
    );

    // inputs: ren wen dhit ihit loaduse jump mispredict halt
    task automatic drive(input logic [7:0] v);
        {dmemREN_mem, dmemWEN_mem, dhit, ihit,
         loaduse, jump_dc, mispredict_mem, halt_mem} = v;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] fz,
                       input logic [3:0] fl, input logic pe, input logic h);
        #1;
        checks++;
        assert ({freeze, flush, pc_en, halted} === {fz, fl, pe, h})
        else begin
            errors++;
            $error("FAIL %s: got frz=%b fl=%b pc=%b h=%b want frz=%b fl=%b pc=%b h=%b",
                   tag, freeze, flush, pc_en, halted, fz, fl, pe, h);
        end
        checks++;
        assert ((freeze & flush) === 4'b0000)
        else begin
            errors++;
            $error("FAIL %s_excl: got frz=%b fl=%b want no overlap",
                   tag, freeze, flush);
        end
    endtask

`ifdef PIPELINE_SEQ_PERF_CNT_EN
    task automatic chk_cnt(input string tag, input logic [31:0] s,
                           input logic [31:0] f);
        checks++;
        assert ({stall_cycles, flush_events} === {s, f})
        else begin
            errors++;
            $error("FAIL %s: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                   tag, stall_cycles, flush_events, s, f);
        end
    endtask
`endif

    initial begin
        nRST = 1'b0;
        drive(8'b0001_0000);
        cyc();
        chk("reset", 4'b0000, 4'b1111, 1'b0, 1'b0);
`ifdef PIPELINE_SEQ_PERF_CNT_EN
        chk_cnt("cnt_reset", 32'd0, 32'd0);
`endif
        // release mid-cycle: forcing drops immediately
        nRST = 1'b1;
        chk("run_first", 4'b0000, 4'b0000, 1'b1, 1'b0);
        cyc();
        chk("run_seq", 4'b0000, 4'b0000, 1'b1, 1'b0);
        cyc();

        // data stall for three cycles, ihit ignored
        drive(8'b1000_0000);
        chk("dstall1", 4'b0111, 4'b1000, 1'b0, 1'b0);
        cyc();
        drive(8'b1001_0000);
        chk("dstall2", 4'b0111, 4'b1000, 1'b0, 1'b0);
        cyc();
        drive(8'b1000_0100);
        chk("dstall3", 4'b0111, 4'b1000, 1'b0, 1'b0);
        cyc();
        drive(8'b1011_0000);
        chk("dhit_done", 4'b0000, 4'b0000, 1'b1, 1'b0);
        cyc();
`ifdef PIPELINE_SEQ_PERF_CNT_EN
        chk_cnt("cnt_dstall", 32'd3, 32'd3);
`endif

        drive(8'b0001_1100);
        chk("loaduse_jump", 4'b0001, 4'b0010, 1'b0, 1'b0);
        cyc();
        drive(8'b0001_0100);
        chk("jump_ihit", 4'b0000, 4'b0001, 1'b1, 1'b0);
        cyc();
        drive(8'b0000_0100);
        chk("jump_noihit", 4'b0000, 4'b0001, 1'b0, 1'b0);
        cyc();
        drive(8'b0000_0000);
        chk("no_ihit", 4'b0000, 4'b0001, 1'b0, 1'b0);
        cyc();
`ifdef PIPELINE_SEQ_PERF_CNT_EN
        chk_cnt("cnt_pre_mp", 32'd6, 32'd7);
`endif
        drive(8'b0000_1110);
        chk("mispredict", 4'b0000, 4'b0111, 1'b1, 1'b0);
        cyc();
`ifdef PIPELINE_SEQ_PERF_CNT_EN
        chk_cnt("cnt_mp", 32'd6, 32'd8);
`endif
        drive(8'b1010_1010);
        chk("dhit_mispredict", 4'b0000, 4'b0111, 1'b1, 1'b0);
        cyc();

        // halt behind a pending store
        drive(8'b0101_0001);
        chk("halt_stall", 4'b0111, 4'b1000, 1'b0, 1'b0);
        cyc();
        drive(8'b0111_0001);
        chk("halt_take", 4'b0000, 4'b0111, 1'b0, 1'b0);
        cyc();
        drive(8'b1001_1111);
        chk("drain", 4'b0000, 4'b0111, 1'b0, 1'b0);
        cyc();
        for (int i = 0; i < 10; i++) begin
            drive(8'($urandom));
            chk("halted_hold", 4'b1111, 4'b0000, 1'b0, 1'b1);
            cyc();
        end

        // async reset mid-HALTED
        drive(8'b0001_0000);
        #2;
        nRST = 1'b0;
        chk("reset_halted", 4'b0000, 4'b1111, 1'b0, 1'b0);
        cyc();
        chk("reset_hold", 4'b0000, 4'b1111, 1'b0, 1'b0);
        nRST = 1'b1;
        chk("resume", 4'b0000, 4'b0000, 1'b1, 1'b0);
        cyc();
        drive(8'b0001_0010);
        chk("resume_mp", 4'b0000, 4'b0111, 1'b1, 1'b0);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Central stall/flush sequencer for the five-stage pipeline. It merges data-memory wait, instruction-fetch wait, load-use hazard, jump, branch-mispredict and halt events into per-latch `freeze`/`flush` vectors and a PC enable. It also owns the halt-drain state machine. It sits between the cache/memory handshake signals, the hazard detector, and the four pipeline latches (bit 0 IF/ID, bit 1 ID/EX, bit 2 EX/MEM, bit 3 MEM/WB).

## Interface
- No parameters; latch count fixed at 4.
- `CLK`  in  1  pipeline clock, rising edge.
- `nRST`  in  1  asynchronous, active-low reset.
- `ihit`  in  1  instruction memory returned valid word this cycle.
- `dhit`  in  1  data memory completed access this cycle.
- `dmemREN_mem`, `dmemWEN_mem`  in  1 each  MEM-stage instruction requests data read/write.
- `loaduse`  in  1  hazard detector: decode operand depends on load in execute.
- `jump_dc`  in  1  J/JAL/JR resolved in decode.
- `mispredict_mem`  in  1  branch in MEM resolved opposite to prediction.
- `halt_mem`  in  1  HALT instruction in MEM.
- `freeze`  out  4  per-latch hold.
- `flush`  out  4  per-latch clear to bubble.
- `pc_en`  out  1  PC register update enable.
- `halted`  out  1  processor halted, sticky.
- `stall_cycles`, `flush_events`  out  32 each  (only with PERF_CNT_EN).

## Operation
- States: RUN, DRAIN, HALTED. 2-bit encoding.
- `dstall` = (`dmemREN_mem` | `dmemWEN_mem`) & !`dhit`.
- RUN evaluates the following in strict priority order. The first match wins, and all unlisted bits are 0.
  1. `dstall`: `freeze`=4'b0111, `flush`=4'b1000, `pc_en`=0.
  2. `halt_mem`: `flush`=4'b0111, `pc_en`=0, next state DRAIN.
  3. `mispredict_mem`: `flush`=4'b0111, `pc_en`=1 (PC loads the corrected target).
  4. `loaduse`: `freeze`=4'b0001, `flush`=4'b0010, `pc_en`=0.
  5. `jump_dc`: `flush`=4'b0001, `pc_en`=`ihit`.
  6. !`ihit`: `flush`=4'b0001, `pc_en`=0.
  7. Otherwise: all 0, `pc_en`=1.
- DRAIN: one cycle that lets the MEM/WB contents write back.
  - `flush`=4'b0111, `freeze`=0, `pc_en`=0.
  - Next state is HALTED unconditionally; all inputs are ignored.
- HALTED: `freeze`=4'b1111, `flush`=0, `pc_en`=0, `halted`=1.
  - All inputs are ignored; only `nRST` exits this state.
- `freeze` and `flush` are never both set for the same bit; this is a bench assertion.

## Timing
- All outputs are Mealy-combinational from the current state and inputs, with zero-cycle latency. State updates on the rising edge of `CLK`.
- `halted` is decoded from state, so it rises one cycle after DRAIN, which is two cycles after `halt_mem` is sampled in RUN.
- While `nRST`=0:
  - State is RUN.
  - Outputs are forced to `flush`=4'b1111, `freeze`=0, `pc_en`=0, `halted`=0.
  - Counters are 0.
- Deasserting `nRST` releases the forcing immediately.
- Reset asserted in DRAIN or HALTED returns the block to RUN asynchronously.
- `dstall` with `halt_mem` in the same cycle: the stall wins and the state stays RUN. The halt is taken on the cycle `dhit` completes, or immediately if no access is pending.
- `dhit` arriving in the same cycle as `mispredict_mem` from a younger instruction: the priority list applies as written, because `dstall`=0.
- `ihit` is ignored during `dstall`, because the IF/ID latch is frozen.

## Configuration
- `PIPELINE_SEQ_PERF_CNT_EN` defined:
  - `stall_cycles` increments on every RUN cycle where `pc_en`=0.
  - `flush_events` increments on every RUN cycle where any `flush` bit is 1.
  - Both saturate at 32'hFFFF_FFFF and freeze in DRAIN/HALTED.
- Undefined: both ports and the counter logic are absent.

## Test plan
- Reset, then sequential `ihit`=1 with no hazards → `freeze`=0, `flush`=0, `pc_en`=1 from the first cycle after `nRST` rises.
- `dmemREN_mem`=1 with `dhit`=0 for 3 cycles, then `dhit`=1 → three cycles of `freeze`=4'b0111, `flush`=4'b1000, `pc_en`=0, then all 0 with `pc_en`=1. With PERF, `stall_cycles`=3.
- `loaduse`=1 together with `jump_dc`=1 → `freeze`=4'b0001, `flush`=4'b0010, `pc_en`=0 (load-use wins).
- `mispredict_mem`=1 with `ihit`=0 → `flush`=4'b0111, `pc_en`=1. With PERF, `flush_events` increments by 1.
- `halt_mem`=1 with `dmemWEN_mem`=1 and `dhit`=0:
  - Cycle 0: stall.
  - Next cycle with `dhit`=1: `flush`=4'b0111.
  - Then DRAIN, then `halted`=1 with `freeze`=4'b1111, holding for 10 cycles with random inputs.
- `nRST` pulsed low mid-HALTED → `halted`=0 and `flush`=4'b1111 asynchronously; RUN behaviour resumes after release.
